// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
`default_nettype none

package imem_loader_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned LANE_W  = $clog2(LANES);
    localparam int unsigned CKSUM_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_LO = 3'd1;
    localparam state_t ST_LEN_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_WRITE  = 3'd4;
    localparam state_t ST_CHECK  = 3'd5;
    localparam state_t ST_DONE   = 3'd6;
    localparam state_t ST_ERROR  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed, checksummed byte stream -> 32-bit instruction memory writes.
// The core is held in reset until a frame arrives with a matching checksum.
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        s_valid_i,
    input  logic [7:0]  s_data_i,
    output logic        s_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_waddr_o,
    output logic [31:0] imem_wdata_o,
    output logic        cpu_rst_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    // One extra bit so a count of exactly DEPTH is representable.
    localparam int unsigned IDX_W = $clog2(DEPTH) + 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [IDX_W-1:0]   len_q,      len_d;
    logic [LANE_W-1:0]  lane_q,     lane_d;
    logic [CKSUM_W-1:0] cksum_q,    cksum_d;
    logic [7:0]         len_lo_q,   len_lo_d;
    logic [31:0]        wdata_q,    wdata_d;

    logic               hs;
    logic [15:0]        len_word;
    logic               len_ok;
    logic [IDX_W-1:0]   idx_inc;

    assign hs       = s_valid_i && s_ready_o;
    assign len_word = {s_data_i, len_lo_q};
    assign len_ok   = (len_word != 16'd0) && (32'(len_word) <= DEPTH);
    assign idx_inc  = word_idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        lane_d     = lane_q;
        cksum_d    = cksum_q;
        len_lo_d   = len_lo_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d    = ST_LEN_LO;
                    word_idx_d = '0;
                    lane_d     = '0;
                    cksum_d    = '0;
                end
            end
            ST_LEN_LO: begin
                if (hs) begin
                    len_lo_d = s_data_i;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (hs) begin
                    if (len_ok) begin
                        len_d   = len_word[IDX_W-1:0];
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DATA: begin
                if (hs) begin
                    wdata_d[{lane_q, 3'b000} +: 8] = s_data_i;
                    cksum_d = cksum_q + s_data_i;
                    lane_d  = lane_q + 1'b1;
                    if (lane_q == LANE_LAST) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_idx_d = idx_inc;
                state_d    = (idx_inc == len_q) ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (hs) begin
                    state_d = (s_data_i == cksum_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            len_q      <= '0;
            lane_q     <= '0;
            cksum_q    <= '0;
            len_lo_q   <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            lane_q     <= lane_d;
            cksum_q    <= cksum_d;
            len_lo_q   <= len_lo_d;
            wdata_q    <= wdata_d;
        end
    end

    // Outputs decode from state/registers only, so reset clears them asynchronously.
    assign s_ready_o    = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                          (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign busy_o       = s_ready_o || (state_q == ST_WRITE);
    assign imem_we_o    = (state_q == ST_WRITE);
    assign imem_waddr_o = {{(32 - IDX_W - 2){1'b0}}, word_idx_q, 2'b00};
    assign imem_wdata_o = wdata_q;
    assign cpu_rst_n_o  = (state_q == ST_DONE);
    assign done_o       = (state_q == ST_DONE);
    assign error_o      = (state_q == ST_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a stream-level reference model.
`default_nettype none

module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        s_valid_i;
    logic [7:0]  s_data_i;
    logic        s_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_waddr_o;
    logic [31:0] imem_wdata_o;
    logic        cpu_rst_n_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_waddr_o (imem_waddr_o),
        .imem_wdata_o (imem_wdata_o),
        .cpu_rst_n_o  (cpu_rst_n_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (stream level) ----------------
    logic [63:0] wr_log[$];
    logic [7:0]  m_fr[$];
    int          m_hs, m_n, k;
    bit          m_busy = 0, m_done = 0, m_err = 0, m_we = 0;
    logic [31:0] m_addr, m_data;
    logic [7:0]  m_sum;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_we = 0; m_hs = 0; m_n = 0;
            m_fr.delete();
        end else begin
            check("busy",      32'(busy_o),      32'(m_busy));
            check("done",      32'(done_o),      32'(m_done));
            check("error",     32'(error_o),     32'(m_err));
            check("cpu_rst_n", 32'(cpu_rst_n_o), 32'(m_done));
            check("imem_we",   32'(imem_we_o),   32'(m_we));
            check("s_ready",   32'(s_ready_o),   32'(m_busy && !m_we));
            if (imem_we_o) wr_log.push_back({imem_waddr_o, imem_wdata_o});
            if (m_we) begin
                check("waddr", imem_waddr_o, m_addr);
                check("wdata", imem_wdata_o, m_data);
            end

            if (m_busy && !m_we && s_valid_i) begin
                m_we = 0;
                m_fr.push_back(s_data_i);
                k = m_hs;
                m_hs++;
                if (k == 1) begin
                    m_n = int'({m_fr[1], m_fr[0]});
                    if (m_n < 1 || m_n > DEPTH) begin
                        m_busy = 0; m_err = 1;
                    end
                end else if (k >= 2 && k < 2 + 4 * m_n) begin
                    if ((k - 2) % 4 == 3) begin
                        m_we   = 1;
                        m_addr = 32'(((k - 2) / 4) * 4);
                        m_data = {m_fr[k], m_fr[k-1], m_fr[k-2], m_fr[k-3]};
                    end
                end else if (k == 2 + 4 * m_n) begin
                    m_sum = 8'h00;
                    for (int i = 2; i < k; i++) m_sum = m_sum + m_fr[i];
                    m_busy = 0;
                    if (m_fr[k] == m_sum) m_done = 1;
                    else                  m_err  = 1;
                end
            end else begin
                m_we = 0;
                if (!m_busy && start_i) begin
                    m_busy = 1; m_done = 0; m_err = 0; m_hs = 0;
                    m_fr.delete();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0]  frame[$];
    logic [63:0] ref_log[$];
    logic [31:0] words[$];

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int tmo;
        tmo = 0;
        while (int'($urandom_range(99)) < gap_pct) begin
            s_valid_i = 1'b0;
            @(posedge clk); #1;
        end
        s_valid_i = 1'b1;
        s_data_i  = b;
        while (!s_ready_o && tmo < 50) begin
            @(posedge clk); #1;
            tmo++;
        end
        if (!s_ready_o) check("ready_timeout", 32'(s_ready_o), 32'd1);
        @(posedge clk); #1;
        s_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int tmo;
        tmo = 0;
        while (busy_o && tmo < 50) begin
            @(posedge clk); #1;
            tmo++;
        end
        if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    task automatic send_frame(input int gap_pct, input int start_at);
        wr_log.delete();
        pulse_start();
        foreach (frame[i]) begin
            if (i == start_at) pulse_start();
            send_byte(frame[i], gap_pct);
        end
        wait_idle();
    endtask

    task automatic build_frame(input bit bad);
        logic [7:0]  ck;
        logic [31:0] w;
        ck = 8'h00;
        frame.delete();
        frame.push_back(8'(words.size()));
        frame.push_back(8'(words.size() >> 8));
        foreach (words[i]) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                frame.push_back(w[8*b +: 8]);
                ck = ck + w[8*b +: 8];
            end
        end
        if (bad) ck = ck ^ 8'h5A;
        frame.push_back(ck);
    endtask

    task automatic check_end(input string tag, input bit good, input int nwr);
        check({tag, "_done"},      32'(done_o),      32'(good));
        check({tag, "_error"},     32'(error_o),     32'(!good));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n_o), 32'(good));
        check({tag, "_nwrites"},   32'(wr_log.size()), 32'(nwr));
    endtask

    initial begin
        int n;
        bit bad;
        rst_n = 1'b0; start_i = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready",   32'(s_ready_o),   32'd0);
        check("rst_imem_we",   32'(imem_we_o),   32'd0);
        check("rst_waddr",     imem_waddr_o,     32'd0);
        check("rst_wdata",     imem_wdata_o,     32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_done",      32'(done_o),      32'd0);
        check("rst_error",     32'(error_o),     32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Payload sum 0x93+0x13+0x01+0xA0 = 0x147 -> checksum 0x47.
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h47};
        send_frame(0, -1);
        check_end("normal", 1'b1, 2);
        if (wr_log.size() == 2) begin
            check("normal_w0", 32'(wr_log[0] == {32'h0, 32'h0000_0093}), 32'd1);
            check("normal_w1", 32'(wr_log[1] == {32'h4, 32'h00A0_0113}), 32'd1);
        end
        ref_log = wr_log;

        send_frame(50, -1);
        check_end("gaps", 1'b1, 2);
        check("gaps_same_writes", 32'(wr_log == ref_log), 32'd1);

        frame[10] = 8'h42;
        send_frame(0, -1);
        check_end("badck", 1'b0, 2);

        frame = '{8'h00, 8'h00};
        send_frame(0, -1);
        check_end("len0", 1'b0, 0);

        frame = '{8'h01, 8'h01};
        send_frame(0, -1);
        check_end("len257", 1'b0, 0);

        words.delete();
        for (int i = 0; i < 256; i++) words.push_back(32'h0000_0013);
        build_frame(1'b0);
        send_frame(0, -1);
        check_end("len256", 1'b1, 256);
        if (wr_log.size() == 256) check("len256_last", wr_log[255][63:32], 32'h0000_03FC);

        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h47};
        send_frame(20, 5);
        check_end("start_busy", 1'b1, 2);

        wr_log.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(frame[i], 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_imem_we",   32'(imem_we_o),   32'd0);
        check("arst_busy",      32'(busy_o),      32'd0);
        check("arst_s_ready",   32'(s_ready_o),   32'd0);
        check("arst_waddr",     imem_waddr_o,     32'd0);
        check("arst_wdata",     imem_wdata_o,     32'd0);
        check("arst_cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
        check("arst_done",      32'(done_o),      32'd0);
        check("arst_error",     32'(error_o),     32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(0, -1);
        check_end("after_rst", 1'b1, 2);

        for (int t = 0; t < 10; t++) begin
            n = int'($urandom_range(1, 6));
            bad = ($urandom_range(2) == 0);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            build_frame(bad);
            send_frame(int'($urandom_range(60)), -1);
            check_end("rand", !bad, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
